// File: rtl/bram_capture_ctrl_if.sv
// bram_capture_ctrl_if: capture control/status bundle between the sample pipeline, BRAM port and CSR bank
interface bram_capture_ctrl_if #(
  parameter int ADDR_WIDTH  = 13,
  parameter int DECIM_WIDTH = 8
);
  logic                   start;
  logic [ADDR_WIDTH-1:0]  sync_addr;
  logic [ADDR_WIDTH-1:0]  length;
  logic [DECIM_WIDTH-1:0] decim;
  logic                   continuous;
  logic                   wen;
  logic [ADDR_WIDTH-1:0]  count;
  logic                   last;
  logic                   busy;
  logic                   done;
  logic                   timeout;
  modport master (
    output start, sync_addr, length, decim, continuous,
    input  wen, count, last, busy, done, timeout
  );
  modport slave (
    input  start, sync_addr, length, decim, continuous,
    output wen, count, last, busy, done, timeout
  );
endinterface

// File: rtl/bram_capture_ctrl.sv
// bram_capture_ctrl: sync-aligned BRAM capture window generator; optional CAPTURE_COUNTER_EN adds a window counter
module bram_capture_ctrl #(
  parameter int ADDR_WIDTH  = 13,
  parameter int DECIM_WIDTH = 8
) (
  input logic clk,
  input logic rst,
  bram_capture_ctrl_if.slave bus
`ifdef CAPTURE_COUNTER_EN
  ,
  output logic [31:0] capture_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, WAIT_SYNC, CAPTURE, DONE} state_t;
  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  len_q, len_d;
  logic [DECIM_WIDTH-1:0] decim_q, decim_d;
  logic                   cont_q, cont_d;
  logic [ADDR_WIDTH-1:0]  wait_q, wait_d;
  logic [DECIM_WIDTH-1:0] dec_q, dec_d;
  logic                   wen_q, wen_d;
  logic [ADDR_WIDTH-1:0]  count_q, count_d;
  logic                   last_q, last_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   timeout_q, timeout_d;
  // Next state and registered outputs; last is precomputed so it lines up with its wen
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    decim_d   = decim_q;
    cont_d    = cont_q;
    wait_d    = wait_q;
    dec_d     = dec_q;
    wen_d     = 1'b0;
    count_d   = count_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE, DONE: if (bus.start) begin
        state_d   = WAIT_SYNC;
        len_d     = bus.length;
        decim_d   = bus.decim;
        cont_d    = bus.continuous;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        wait_d    = '0;
        count_d   = '0;
      end
      WAIT_SYNC: begin
        wait_d = wait_q + 1'b1;
        if (bus.sync_addr == '0) begin
          state_d = CAPTURE;
          wen_d   = 1'b1;
          count_d = '0;
          dec_d   = '0;
        end else if (&wait_q) begin
          state_d   = DONE;
          timeout_d = 1'b1;
          done_d    = 1'b1;
        end
      end
      CAPTURE: begin
        done_d  = 1'b0;
        dec_d   = (dec_q == decim_q) ? '0 : dec_q + 1'b1;
        wen_d   = dec_d == '0;
        count_d = wen_q ? count_q + 1'b1 : count_q;
        if (wen_q && last_q) begin
          done_d  = 1'b1;
          count_d = cont_q ? '0 : count_q;
          state_d = cont_q ? CAPTURE : DONE;
          wen_d   = cont_q && wen_d;
        end
      end
      default: state_d = IDLE;
    endcase
    last_d = wen_d && (count_d == len_q - 1'b1);
    busy_d = (state_d == WAIT_SYNC) || (state_d == CAPTURE);
  end
  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      decim_q   <= '0;
      cont_q    <= 1'b0;
      wait_q    <= '0;
      dec_q     <= '0;
      wen_q     <= 1'b0;
      count_q   <= '0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      decim_q   <= decim_d;
      cont_q    <= cont_d;
      wait_q    <= wait_d;
      dec_q     <= dec_d;
      wen_q     <= wen_d;
      count_q   <= count_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end
  assign bus.wen     = wen_q;
  assign bus.count   = count_q;
  assign bus.last    = last_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.timeout = timeout_q;
`ifdef CAPTURE_COUNTER_EN
  logic [31:0] capture_cnt_q, capture_cnt_d;
  // Completed-window tally; survives start, cleared only by reset
  always_comb capture_cnt_d = capture_cnt_q + {31'd0, wen_q && last_q};
  // Window tally register
  always_ff @(posedge clk) capture_cnt_q <= rst ? '0 : capture_cnt_d;
  assign capture_cnt = capture_cnt_q;
`endif
endmodule
